// File: rtl/spi_display_rx.sv
// spi_display_rx: SPI mode-0 target for the 4-wire ILI9341 display bus.
// Received bytes are tagged with D/C and a first-in-frame flag, then queued
// in a small FIFO behind a valid/ready interface.
module spi_display_rx #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_clk,
    input  logic       display_csb,
    input  logic       spi_mosi,
    input  logic       data_commandb,
    output logic [7:0] rx_data,
    output logic       rx_is_data,
    output logic       rx_first,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       overflow,
    output logic       busy
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] csb_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] dc_sync;
    logic                   sclk_prev;
    logic                   csb_prev;

    logic sclk_s;
    logic csb_s;
    logic mosi_s;
    logic dc_s;
    logic sclk_rise;
    logic csb_rise;

    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic       first_pending;
    logic       push_req;
    logic [9:0] push_word;

    logic [9:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        pop;
    logic        do_push;

    // Synchronizer chains (reset to idle bus level) plus edge-detect history flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            csb_sync  <= '1;
            mosi_sync <= '0;
            dc_sync   <= '0;
            sclk_prev <= 1'b0;
            csb_prev  <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
            csb_sync  <= {csb_sync[SYNC_STAGES-2:0], display_csb};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            dc_sync   <= {dc_sync[SYNC_STAGES-2:0], data_commandb};
            sclk_prev <= sclk_s;
            csb_prev  <= csb_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign csb_s     = csb_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign dc_s      = dc_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign csb_rise  = csb_s & ~csb_prev;

    // Bit assembly; a completed byte is staged in push_req/push_word for one
    // cycle before entering the FIFO, which sets the E+SYNC_STAGES+1 latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt       <= '0;
            shift         <= '0;
            first_pending <= 1'b1;
            push_req      <= 1'b0;
            push_word     <= '0;
        end else begin
            push_req <= 1'b0;
            if (csb_rise) begin
                bit_cnt       <= '0;
                first_pending <= 1'b1;
            end else if (sclk_rise && !csb_s) begin
                shift   <= {shift[6:0], mosi_s};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    push_req      <= 1'b1;
                    push_word     <= {first_pending, dc_s, shift[6:0], mosi_s};
                    first_pending <= 1'b0;
                end
            end
        end
    end

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = !empty && rx_ready;
    assign do_push = push_req && (!full || pop);

    // FIFO storage, pointers and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_word;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_req && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Head-of-FIFO presentation and status outputs.
    always_comb begin
        {rx_first, rx_is_data, rx_data} = mem[rd_ptr[AW-1:0]];
        rx_valid = !empty;
        busy     = ~csb_s;
    end

endmodule

// File: tb/tb_spi_display_rx.sv
// tb_spi_display_rx: directed table/sequence checks plus randomized frames
// compared against a queue-based reference of expected tagged bytes.
module tb_spi_display_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_clk;
    logic       display_csb;
    logic       spi_mosi;
    logic       data_commandb;
    logic [7:0] rx_data;
    logic       rx_is_data;
    logic       rx_first;
    logic       rx_valid;
    logic       rx_ready;
    logic       overflow;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic man_ready  = 1'b0;
    logic auto_mode  = 1'b0;
    logic auto_ready = 1'b0;
    logic [9:0] exp_q [$];

    typedef struct {
        logic [7:0] b;
        logic       dc;
        logic       first;
    } vec_t;
    vec_t tbl [5];

    assign rx_ready = auto_mode ? auto_ready : man_ready;

    always #5 clk = ~clk;

    spi_display_rx #(.DEPTH(4), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .spi_clk       (spi_clk),
        .display_csb   (display_csb),
        .spi_mosi      (spi_mosi),
        .data_commandb (data_commandb),
        .rx_data       (rx_data),
        .rx_is_data    (rx_is_data),
        .rx_first      (rx_first),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .overflow      (overflow),
        .busy          (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input logic dc, input int n);
        for (int i = 0; i < n; i++) begin
            spi_mosi      = b[7-i];
            data_commandb = dc;
            cyc(4);
            spi_clk = 1'b1;
            cyc(4);
            spi_clk = 1'b0;
        end
    endtask

    task automatic csb_low();
        display_csb = 1'b0;
        cyc(4);
    endtask

    task automatic csb_high();
        display_csb = 1'b1;
        cyc(4);
    endtask

    task automatic pop_check(input string name, input logic [9:0] exp);
        int k = 0;
        while (!rx_valid && k < 40) begin
            cyc(1);
            k++;
        end
        chk({name, "_valid"}, 32'(rx_valid), 32'd1);
        chk(name, 32'({rx_first, rx_is_data, rx_data}), 32'(exp));
        man_ready = 1'b1;
        cyc(1);
        man_ready = 1'b0;
    endtask

    // Random-mode consumer: random ready, each accepted head compared with the reference queue.
    always @(negedge clk) begin
        if (auto_mode) begin
            auto_ready = ($urandom_range(3) != 0);
            if (rx_valid && auto_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rand_unexpected: got %0h expected none",
                             {rx_first, rx_is_data, rx_data});
                end else begin
                    chk("rand_byte", 32'({rx_first, rx_is_data, rx_data}), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int k;
        logic [7:0] rb;
        logic       rdc;

        rst           = 1'b1;
        spi_clk       = 1'b0;
        display_csb   = 1'b1;
        spi_mosi      = 1'b0;
        data_commandb = 1'b0;
        cyc(3);
        rst = 1'b0;
        cyc(1);
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_head", 32'({rx_first, rx_is_data, rx_data}), 32'd0);

        // Single command with latency measurement on the 8th rise.
        csb_low();
        chk("busy_low", 32'(busy), 32'd1);
        send_bits(8'h2A, 1'b0, 7);
        spi_mosi      = 1'b0;
        data_commandb = 1'b0;
        cyc(4);
        spi_clk = 1'b1;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            cyc(1);
            if (rx_valid && lat == 0) lat = i;
        end
        spi_clk = 1'b0;
        chk("latency", 32'(lat), 32'd4);
        csb_high();
        chk("busy_high", 32'(busy), 32'd0);
        pop_check("cmd", {1'b1, 1'b0, 8'h2A});
        cyc(2);
        chk("cmd_empty", 32'(rx_valid), 32'd0);

        // Five-byte frame from the vector table.
        tbl[0] = '{8'h2C, 1'b0, 1'b1};
        tbl[1] = '{8'hF8, 1'b1, 1'b0};
        tbl[2] = '{8'h00, 1'b1, 1'b0};
        tbl[3] = '{8'h07, 1'b1, 1'b0};
        tbl[4] = '{8'hE0, 1'b1, 1'b0};
        csb_low();
        for (int i = 0; i < 5; i++) begin
            send_bits(tbl[i].b, tbl[i].dc, 8);
            pop_check("frame", {tbl[i].first, tbl[i].dc, tbl[i].b});
        end
        csb_high();
        chk("frame_empty", 32'(rx_valid), 32'd0);

        // Aborted partial byte followed by a fresh frame.
        csb_low();
        send_bits(8'hA5, 1'b1, 5);
        csb_high();
        cyc(4);
        chk("abort_nopush", 32'(rx_valid), 32'd0);
        csb_low();
        send_bits(8'h3C, 1'b1, 8);
        csb_high();
        pop_check("abort_next", {1'b1, 1'b1, 8'h3C});
        cyc(2);
        chk("abort_empty", 32'(rx_valid), 32'd0);

        // Overflow with the consumer stalled.
        csb_low();
        for (int i = 1; i <= 4; i++) send_bits(8'(i), 1'b1, 8);
        cyc(8);
        chk("ovf_before", 32'(overflow), 32'd0);
        send_bits(8'h05, 1'b1, 8);
        cyc(8);
        chk("ovf_set", 32'(overflow), 32'd1);
        send_bits(8'h06, 1'b1, 8);
        cyc(8);
        csb_high();
        for (int i = 1; i <= 4; i++) pop_check("ovf_pop", {(i == 1), 1'b1, 8'(i)});
        cyc(3);
        chk("ovf_empty", 32'(rx_valid), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("ovf_rst", 32'(overflow), 32'd0);

        // Push and pop in the same cycle while full.
        csb_low();
        for (int i = 1; i <= 4; i++) send_bits(8'h10 + 8'(i), 1'b1, 8);
        send_bits(8'h15, 1'b1, 7);
        spi_mosi      = 1'b1;
        data_commandb = 1'b1;
        cyc(4);
        spi_clk = 1'b1;
        cyc(3);
        man_ready = 1'b1;
        cyc(1);
        man_ready = 1'b0;
        cyc(4);
        spi_clk = 1'b0;
        cyc(4);
        chk("simul_ovf", 32'(overflow), 32'd0);
        csb_high();
        for (int i = 2; i <= 5; i++) pop_check("simul_pop", {1'b0, 1'b1, 8'h10 + 8'(i)});
        cyc(2);
        chk("simul_empty", 32'(rx_valid), 32'd0);

        // Reset in the middle of a byte with entries queued.
        csb_low();
        send_bits(8'h21, 1'b1, 8);
        send_bits(8'h22, 1'b1, 8);
        send_bits(8'h33, 1'b1, 3);
        chk("mid_queued", 32'(rx_valid), 32'd1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("mid_valid", 32'(rx_valid), 32'd0);
        chk("mid_overflow", 32'(overflow), 32'd0);
        csb_high();
        csb_low();
        send_bits(8'h5A, 1'b0, 8);
        csb_high();
        pop_check("mid_next", {1'b1, 1'b0, 8'h5A});
        cyc(2);
        chk("mid_empty", 32'(rx_valid), 32'd0);

        // Randomized frames against the reference queue.
        auto_mode = 1'b1;
        for (int f = 0; f < 25; f++) begin
            csb_low();
            for (int j = 0; j < int'($urandom_range(1, 4)); j++) begin
                rb  = 8'($urandom);
                rdc = 1'($urandom_range(1));
                exp_q.push_back({(j == 0), rdc, rb});
                send_bits(rb, rdc, 8);
            end
            if ($urandom_range(3) == 0) begin
                send_bits(8'($urandom), 1'($urandom_range(1)), int'($urandom_range(1, 7)));
            end
            csb_high();
            cyc(int'($urandom_range(0, 6)));
        end
        k = 0;
        while ((exp_q.size() != 0 || rx_valid) && k < 300) begin
            cyc(1);
            k++;
        end
        chk("rand_drain", 32'(exp_q.size()), 32'd0);
        chk("rand_empty", 32'(rx_valid), 32'd0);
        chk("rand_overflow", 32'(overflow), 32'd0);
        auto_mode = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_display_rx.md
# spi_display_rx

Synthesizable SPI target that receives the 4-wire ILI9341-style display bus (spi_clk, display_csb, spi_mosi, data_commandb) and turns it into a stream of tagged bytes. It is the receiving end of the display link driven by the ILI9341 controller in main. Uses: an in-fabric display emulator, and checking captured command/pixel traffic against VRAM contents. Bytes are buffered in a small FIFO and presented on a valid/ready interface.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- SYNC_STAGES, 2: synchronizer flops on each SPI input; at least 2.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- spi_clk  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0); asynchronous to clk.
- display_csb  in  1  chip select, active low.
- spi_mosi  in  1  serial data, MSB first.
- data_commandb  in  1  1 = data byte, 0 = command byte.
- rx_data  out  8  received byte at the FIFO head.
- rx_is_data  out  1  data_commandb value captured with that byte.
- rx_first  out  1  byte is the first one after a display_csb falling edge.
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  consumer accepts the head entry when rx_valid && rx_ready.
- overflow  out  1  sticky; a completed byte was dropped because the FIFO was full.
- busy  out  1  synchronized display_csb is low (frame in progress).

## Operation
- Synchronization:
  - spi_clk, display_csb, spi_mosi and data_commandb each pass through SYNC_STAGES flops.
  - One more flop on spi_clk feeds rise detection: sync high, previous low.
- Receive state, held in a 3-bit bit counter, an 8-bit shift register and a first_pending flag:
  - On an spi_clk rise while synced csb is low: shift = {shift[6:0], mosi}; counter increments.
  - The counter wraps 7 -> 0. On that 8th rise, push {first_pending, dc, {shift[6:0], mosi}}.
  - first_pending is cleared on the push.
  - dc is sampled on the 8th rise; the ILI9341 latches D/C on bit D0.
- Rises seen while synced csb is high are ignored.
- Synced csb rising edge:
  - Counter goes to 0 and any partial byte is discarded, with no push.
  - first_pending is set to 1.
- FIFO:
  - DEPTH entries of 10 bits, with read and write pointers one bit wider than log2(DEPTH).
  - full = MSBs differ and the low bits are equal; empty = pointers equal.
  - Pop on rx_valid && rx_ready.
  - Push when full with no pop in the same cycle: the entry is dropped, the write pointer is unchanged, and overflow goes to 1.
  - Push and pop in the same cycle when full: both happen; no overflow.
  - Push and pop in the same cycle when empty: no pop occurs (rx_valid was 0); the push occurs.
- rx_data, rx_is_data and rx_first show the FIFO head. They are don't-care while rx_valid = 0.
- overflow is cleared only by rst.

## Timing
- Reset values:
  - rx_valid = 0, overflow = 0, busy = 0.
  - rx_data = 0, rx_is_data = 0, rx_first = 0.
  - Counter = 0, both pointers = 0, first_pending = 1.
  - All synchronizer flops are reset to the idle bus level: csb = 1, spi_clk = 0, others = 0.
- rst during a byte discards the partial byte and all FIFO contents. Reception restarts on the next csb fall.
- Latency: let edge E be the first clk edge at which synchronizer stage 1 holds the 8th spi_clk high.
  - rx_valid is 1 in the cycle after clk edge E + SYNC_STAGES + 1, i.e. E+3 for the defaults.
- busy follows display_csb with SYNC_STAGES cycles of delay.
- Bus-side requirements:
  - spi_clk high time and low time each at least 2 clk periods.
  - mosi and dc stable from 2 clk periods before each rising spi_clk edge until 2 clk periods after it.
  - csb high time at least 2 clk periods.
- Throughput: one push per 8 spi_clk periods. The consumer may hold rx_ready low indefinitely; bytes arriving while the FIFO is full are lost, and overflow records it.

## Test plan
- Single command: drive csb low, send 0x2A with dc = 0, then csb high.
  - Exactly one entry: rx_data = 0x2A, rx_is_data = 0, rx_first = 1.
  - rx_valid rises E+3 cycles after the 8th spi_clk rise.
- Frame of 5 bytes: 0x2C with dc = 0, then 0xF8, 0x00, 0x07, 0xE0 with dc = 1, rx_ready held high.
  - Entries in order; only the first has rx_first = 1.
  - rx_is_data reads 0, 1, 1, 1, 1.
- Aborted byte: 5 bits of 0xA5, then csb high, then a new frame with 0x3C.
  - Only 0x3C is received, with rx_first = 1; the partial byte is never pushed.
- Overflow: rx_ready = 0; send 6 bytes 0x01 to 0x06 with DEPTH = 4.
  - After the 5th byte completes: overflow = 1 and FIFO holds 0x01 to 0x04.
  - Releasing rx_ready pops 0x01 to 0x04, then rx_valid = 0.
- Simultaneous push and pop at full: fill with 4 bytes, then pulse rx_ready for one cycle in the push cycle of byte 5.
  - overflow stays 0; the FIFO holds bytes 2 to 5.
- Reset mid-byte: assert rst after 3 bits, with 2 entries queued.
  - rx_valid = 0 and overflow = 0 the cycle after.
  - The next complete frame is received normally, with rx_first = 1.
